// File: rtl/icache_mshr.sv
// Miss-status holding register between the instruction cache and memory: tracks
// outstanding line misses, merges duplicates, issues reads and delivers registered fills.
module icache_mshr #(
    parameter int NUM_ENTRIES      = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int LINE_OFFSET_BITS = 3,
    parameter int TAG_WIDTH        = 4,
    parameter int BLOCK_BITS       = 64,
    localparam int CNT_W           = $clog2(NUM_ENTRIES + 1),
    localparam int LINE_W          = ADDR_WIDTH - LINE_OFFSET_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  miss_ready,
    output logic                  miss_merged,
    input  logic                  flush,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_accepted,
    input  logic [TAG_WIDTH-1:0]  mem_transaction_tag,
    input  logic [BLOCK_BITS-1:0] mem_data,
    input  logic [TAG_WIDTH-1:0]  mem_data_tag,
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [BLOCK_BITS-1:0] fill_data,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  full
);

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        PENDING   = 2'd1,
        WAIT_DATA = 2'd2
    } state_e;

    state_e                state_q [NUM_ENTRIES];
    state_e                state_d [NUM_ENTRIES];
    logic [LINE_W-1:0]     line_q  [NUM_ENTRIES];
    logic [LINE_W-1:0]     line_d  [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_q   [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_d   [NUM_ENTRIES];

    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  fill_valid_q, fill_valid_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [BLOCK_BITS-1:0] fill_data_q, fill_data_d;

    logic [LINE_W-1:0]      miss_line;
    logic [LINE_W-1:0]      iss_line, ret_line;
    logic [NUM_ENTRIES-1:0] alloc_oh, iss_oh, ret_oh;
    logic                   hit, any_free, any_pend, do_alloc, issue_taken;
    logic                   unused_offset;

    assign miss_line     = miss_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS];
    assign unused_offset = ^miss_addr[LINE_OFFSET_BITS-1:0];

    // Scan entries: address match, lowest FREE, lowest PENDING and returning-tag match.
    always_comb begin
        hit      = 1'b0;
        any_free = 1'b0;
        any_pend = 1'b0;
        alloc_oh = '0;
        iss_oh   = '0;
        ret_oh   = '0;
        iss_line = '0;
        ret_line = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state_q[i] != FREE && line_q[i] == miss_line) hit = 1'b1;
            if (state_q[i] == FREE && !any_free) begin
                alloc_oh[i] = 1'b1;
                any_free    = 1'b1;
            end
            if (state_q[i] == PENDING && !any_pend) begin
                iss_oh[i] = 1'b1;
                any_pend  = 1'b1;
                iss_line  = line_q[i];
            end
            if (state_q[i] == WAIT_DATA && mem_data_tag != '0 && tag_q[i] == mem_data_tag) begin
                ret_oh[i] = 1'b1;
                ret_line  = line_q[i];
            end
        end
    end

    // A flush cycle neither accepts nor merges misses and suppresses the issue.
    assign miss_merged   = miss_valid & hit & ~flush;
    assign miss_ready    = ~flush & ((miss_valid & hit) | any_free);
    assign do_alloc      = miss_valid & ~hit & any_free & ~flush;
    assign mem_req_valid = any_pend & ~flush;
    assign mem_req_addr  = {iss_line, {LINE_OFFSET_BITS{1'b0}}};
    assign issue_taken   = mem_req_valid & mem_req_accepted & (mem_transaction_tag != '0);

    always_comb begin
        outstanding_d = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            line_d[i]  = line_q[i];
            tag_d[i]   = tag_q[i];
            if (flush && state_q[i] == PENDING) state_d[i] = FREE;
            if (iss_oh[i] && issue_taken) begin
                state_d[i] = WAIT_DATA;
                tag_d[i]   = mem_transaction_tag;
            end
            if (ret_oh[i]) state_d[i] = FREE;
            if (alloc_oh[i] && do_alloc) begin
                state_d[i] = PENDING;
                line_d[i]  = miss_line;
            end
            if (state_d[i] != FREE) outstanding_d = outstanding_d + CNT_W'(1);
        end
        fill_valid_d = |ret_oh;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        if (|ret_oh) begin
            fill_addr_d = {ret_line, {LINE_OFFSET_BITS{1'b0}}};
            fill_data_d = mem_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= FREE;
            outstanding_q <= '0;
            fill_valid_q  <= 1'b0;
            fill_addr_q   <= '0;
            fill_data_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= state_d[i];
            outstanding_q <= outstanding_d;
            fill_valid_q  <= fill_valid_d;
            fill_addr_q   <= fill_addr_d;
            fill_data_q   <= fill_data_d;
        end
    end

    // Line address and tag are only meaningful while the entry is non-FREE.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            line_q[i] <= line_d[i];
            tag_q[i]  <= tag_d[i];
        end
    end

    assign outstanding = outstanding_q;
    assign full        = (outstanding_q == CNT_W'(NUM_ENTRIES));
    assign fill_valid  = fill_valid_q;
    assign fill_addr   = fill_addr_q;
    assign fill_data   = fill_data_q;

endmodule

// File: tb/tb_icache_mshr.sv
// Scoreboard bench for icache_mshr: directed scenarios plus randomized traffic
// checked against a slot-level behavioural model.
module tb_icache_mshr;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        miss_valid = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        miss_ready, miss_merged;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_accepted = 1'b0;
    logic [3:0]  mem_transaction_tag = '0;
    logic [63:0] mem_data = '0;
    logic [3:0]  mem_data_tag = '0;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [63:0] fill_data;
    logic [2:0]  outstanding;
    logic        full;

    always #5 clock = ~clock;

    icache_mshr #(
        .NUM_ENTRIES(N), .ADDR_WIDTH(32), .LINE_OFFSET_BITS(3), .TAG_WIDTH(4), .BLOCK_BITS(64)
    ) dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr),
        .miss_ready(miss_ready), .miss_merged(miss_merged),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_accepted(mem_req_accepted), .mem_transaction_tag(mem_transaction_tag),
        .mem_data(mem_data), .mem_data_tag(mem_data_tag),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .outstanding(outstanding), .full(full)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: one slot per entry, states FREE / PEND / WAIT.
    localparam int S_FREE = 0, S_PEND = 1, S_WAIT = 2;
    int          m_st   [N];
    logic [31:0] m_line [N];
    logic [3:0]  m_tag  [N];

    typedef struct {
        int          cyc;
        bit          rdy;
        bit          mrg;
        bit          rv;
        logic [31:0] ra;
        int          outst;
    } comb_t;
    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [63:0] data;
    } fill_t;

    comb_t      exp_comb[$];
    fill_t      exp_fill[$];
    comb_t      mc;
    fill_t      mf;
    logic [3:0] stale_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    function automatic bit tag_in_use(input logic [3:0] t);
        for (int i = 0; i < N; i++)
            if (m_st[i] == S_WAIT && m_tag[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] free_tag();
        logic [3:0] t;
        t = 4'($urandom_range(1, 15));
        for (int k = 0; k < 16; k++)
            if (tag_in_use(t)) t = (t == 4'd15) ? 4'd1 : t + 4'd1;
        return t;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_st[i] = S_FREE;
    endtask

    // One clock of stimulus: drive, predict this cycle's outputs, advance the model.
    task automatic step(input bit mv, input logic [31:0] ma, input bit fl, input bit acc,
                        input logic [3:0] tt, input logic [3:0] dt, input logic [63:0] dd);
        comb_t       c;
        fill_t       f;
        bit          hit;
        int          pend_i, free_i, ret_i, cnt;
        logic [31:0] ml;
        @(posedge clock);
        #1;
        miss_valid = mv; miss_addr = ma; flush = fl; mem_req_accepted = acc;
        mem_transaction_tag = tt; mem_data_tag = dt; mem_data = dd;
        ml  = ma & ~32'h7;
        hit = 0; pend_i = -1; free_i = -1; ret_i = -1; cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] != S_FREE) cnt++;
            if (m_st[i] != S_FREE && m_line[i] == ml) hit = 1;
            if (m_st[i] == S_FREE && free_i < 0) free_i = i;
            if (m_st[i] == S_PEND && pend_i < 0) pend_i = i;
            if (m_st[i] == S_WAIT && dt != 0 && m_tag[i] == dt) ret_i = i;
        end
        c.cyc   = cyc;
        c.mrg   = mv && hit && !fl;
        c.rdy   = !fl && ((mv && hit) || free_i >= 0);
        c.rv    = (pend_i >= 0) && !fl;
        c.ra    = c.rv ? m_line[pend_i] : 32'h0;
        c.outst = cnt;
        exp_comb.push_back(c);
        if (fl)
            for (int i = 0; i < N; i++) if (m_st[i] == S_PEND) m_st[i] = S_FREE;
        if (c.rv && acc && tt != 0) begin
            m_st[pend_i]  = S_WAIT;
            m_tag[pend_i] = tt;
        end
        if (ret_i >= 0) begin
            f.due = cyc + 1; f.addr = m_line[ret_i]; f.data = dd;
            exp_fill.push_back(f);
            m_st[ret_i] = S_FREE;
        end
        if (mv && !hit && free_i >= 0 && !fl) begin
            m_st[free_i]   = S_PEND;
            m_line[free_i] = ml;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 32'h0, 0, 0, 4'h0, 4'h0, 64'h0);
    endtask

    task automatic rand_cycles(input int n);
        bit          mv, fl, acc;
        logic [31:0] ma;
        logic [3:0]  tt, dt;
        logic [3:0]  wt[$];
        int          r;
        for (int k = 0; k < n; k++) begin
            mv  = $urandom_range(0, 99) < 60;
            ma  = 32'h4000 + ($urandom_range(0, 7) << 3) + $urandom_range(0, 7);
            fl  = $urandom_range(0, 99) < 4;
            acc = $urandom_range(0, 99) < 50;
            tt  = ($urandom_range(0, 3) == 0) ? 4'h0 : free_tag();
            wt.delete();
            for (int i = 0; i < N; i++) if (m_st[i] == S_WAIT) wt.push_back(m_tag[i]);
            r  = $urandom_range(0, 99);
            dt = 4'h0;
            if (r < 40 && wt.size() > 0) dt = wt[$urandom_range(0, wt.size() - 1)];
            else if (r < 50) dt = free_tag();
            step(mv, ma, fl, acc, tt, dt, {$urandom, $urandom});
        end
    endtask

    task automatic check_reset_values();
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill_addr", fill_addr, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_full", full, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_miss_merged", miss_merged, 0);
    endtask

    // Assert reset between edges; outputs must fall back without waiting for a clock.
    task automatic async_reset();
        @(posedge clock);
        #7;
        miss_valid = 0; flush = 0; mem_req_accepted = 0;
        mem_transaction_tag = '0; mem_data_tag = '0;
        for (int i = 0; i < N; i++) if (m_st[i] == S_WAIT) stale_q.push_back(m_tag[i]);
        reset = 1'b0;
        #1;
        check_reset_values();
        model_clear();
        exp_fill.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_comb.size() > 0 && exp_comb[0].cyc == cyc) begin
                mc = exp_comb.pop_front();
                chk("miss_ready", miss_ready, mc.rdy);
                chk("miss_merged", miss_merged, mc.mrg);
                chk("mem_req_valid", mem_req_valid, mc.rv);
                if (mc.rv) chk("mem_req_addr", mem_req_addr, mc.ra);
                chk("outstanding", outstanding, mc.outst);
                chk("full", full, mc.outst == N);
            end
            if (fill_valid) begin
                if (exp_fill.size() == 0) chk("fill_unexpected", fill_valid, 0);
                else begin
                    mf = exp_fill.pop_front();
                    chk("fill_cycle", cyc, mf.due);
                    chk("fill_addr", fill_addr, mf.addr);
                    chk("fill_data", fill_data, mf.data);
                end
            end else if (exp_fill.size() > 0 && exp_fill[0].due <= cyc) begin
                mf = exp_fill.pop_front();
                chk("fill_valid", fill_valid, 1);
            end
        end
    end

    initial begin
        model_clear();
        #1;
        check_reset_values();
        @(posedge clock);
        #1;
        reset  = 1'b1;
        mon_en = 1;

        // Single miss, issue with tag 3, return, fill
        step(1, 32'h1004, 0, 0, 4'h0, 4'h0, 64'h0);
        step(0, 32'h0,    0, 1, 4'h3, 4'h0, 64'h0);
        step(0, 32'h0,    0, 0, 4'h0, 4'h3, 64'hAB);
        idle(2);

        // Duplicate miss merges
        step(1, 32'h2000, 0, 0, 4'h0, 4'h0, 64'h0);
        step(1, 32'h2006, 0, 0, 4'h0, 4'h0, 64'h0);
        step(0, 32'h0,    0, 1, 4'h4, 4'h0, 64'h0);
        step(0, 32'h0,    0, 0, 4'h0, 4'h4, 64'h2222);
        idle(2);

        // Fill all entries with memory never accepting
        for (int i = 0; i < N; i++) step(1, 32'h3000 + 32'(i * 8), 0, 0, 4'h0, 4'h0, 64'h0);
        step(1, 32'h3020, 0, 0, 4'h0, 4'h0, 64'h0);
        step(1, 32'h300C, 0, 0, 4'h0, 4'h0, 64'h0);
        step(1, 32'h3028, 1, 1, 4'h6, 4'h0, 64'h0);
        idle(1);

        // Out-of-order returns
        step(1, 32'h100, 0, 0, 4'h0, 4'h0, 64'h0);
        step(1, 32'h200, 0, 1, 4'h1, 4'h0, 64'h0);
        step(0, 32'h0,   0, 1, 4'h2, 4'h0, 64'h0);
        step(0, 32'h0,   0, 0, 4'h0, 4'h2, 64'h0200_0200);
        step(0, 32'h0,   0, 0, 4'h0, 4'h1, 64'h0100_0100);
        idle(2);

        // Rejections with tag 0, then acceptance with tag 5
        step(1, 32'h500, 0, 0, 4'h0, 4'h0, 64'h0);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 1, 4'h0, 4'h0, 64'h0);
        step(0, 32'h0, 0, 1, 4'h5, 4'h0, 64'h0);
        step(0, 32'h0, 0, 0, 4'h0, 4'h5, 64'h5555);
        idle(2);

        // Flush keeps WAIT_DATA entries; stray tag is ignored
        step(1, 32'h600, 0, 0, 4'h0, 4'h0, 64'h0);
        step(1, 32'h700, 0, 1, 4'h7, 4'h0, 64'h0);
        step(1, 32'h800, 1, 1, 4'h8, 4'h0, 64'h0);
        step(0, 32'h0,   0, 0, 4'h0, 4'h7, 64'h7777);
        step(0, 32'h0,   0, 0, 4'h0, 4'h9, 64'h9999);
        idle(2);

        // Asynchronous reset with entries in flight; stale tags must not fill
        step(1, 32'h800, 0, 0, 4'h0, 4'h0, 64'h0);
        step(0, 32'h0,   0, 1, 4'hA, 4'h0, 64'h0);
        step(1, 32'h900, 0, 0, 4'h0, 4'h0, 64'h0);
        async_reset();
        step(1, 32'h800, 0, 0, 4'h0, 4'h0, 64'h0);
        while (stale_q.size() > 0) step(0, 32'h0, 0, 0, 4'h0, stale_q.pop_front(), 64'hDEAD);
        idle(2);

        rand_cycles(1500);
        async_reset();
        while (stale_q.size() > 0) step(0, 32'h0, 0, 0, 4'h0, stale_q.pop_front(), 64'hBEEF);
        rand_cycles(500);
        idle(3);

        @(posedge clock);
        @(negedge clock);
        #1;
        chk("fill_queue_drained", exp_fill.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
